// File: rtl/soc_mem_pkg.sv
// Shared definitions for the data-memory subsystem: size codes, LSU FSM states
// and the byte-count helper used by both the LSU and the data memory.
package soc_mem_pkg;

  localparam logic [1:0] SIZE_WORD = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_BYTE = 2'b10;
  localparam logic [1:0] SIZE_NONE = 2'b11;

  typedef enum logic [1:0] {
    LSU_IDLE   = 2'd0,
    LSU_ACCESS = 2'd1,
    LSU_RESP   = 2'd2
  } lsu_state_e;

  function automatic logic [2:0] nbytes(input logic [1:0] size);
    case (size)
      SIZE_WORD: nbytes = 3'd4;
      SIZE_HALF: nbytes = 3'd2;
      SIZE_BYTE: nbytes = 3'd1;
      default:   nbytes = 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_extend.sv
// Load-data extender: takes the memory's right-aligned, zero-extended read data
// and sign- or zero-extends it to 32 bits according to the access size.
module lsu_load_extend
  import soc_mem_pkg::*;
(
  input  logic [31:0] i_rd,
  input  logic [1:0]  i_size,
  input  logic        i_signed,
  output logic [31:0] o_data
);

  logic w_hsign;
  logic w_bsign;

  assign w_hsign = i_signed & i_rd[15];
  assign w_bsign = i_signed & i_rd[7];

  always_comb begin
    o_data = i_rd;
    case (i_size)
      SIZE_WORD: o_data = i_rd;
      SIZE_HALF: o_data = {{16{w_hsign}}, i_rd[15:0]};
      SIZE_BYTE: o_data = {{24{w_bsign}}, i_rd[7:0]};
      default:   o_data = '0;
    endcase
  end

endmodule

// File: rtl/lsu_mem_master.sv
// Load/store initiator: accepts one CPU request at a time, screens it for
// alignment/range faults, runs a single memory access and returns one response.
module lsu_mem_master
  import soc_mem_pkg::*;
#(
  parameter int MEM_BYTES   = 64,
  parameter int WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wd,
  output logic [1:0]  mem_size,
  input  logic [31:0] mem_rd
);

  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_STATES);
  localparam logic [32:0] MEM_LIMIT = 33'(MEM_BYTES);

  lsu_state_e  r_state;
  lsu_state_e  w_state_nxt;
  logic        r_alive;
  logic        r_we;
  logic        r_signed;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [1:0]  r_size;
  logic [3:0]  r_wait_cnt;
  logic [31:0] r_rdata;
  logic        r_err;

  logic        w_accept;
  logic        w_commit;
  logic        w_access;
  logic        w_fault;
  logic [32:0] w_end;
  logic [31:0] w_ext;

  // End address is formed in 33 bits so an access near 2^32 cannot wrap into range.
  assign w_end   = {1'b0, req_addr} + {30'd0, nbytes(req_size)};
  assign w_fault = (req_size == SIZE_NONE)
                || ((req_size == SIZE_WORD) && (req_addr[1:0] != 2'b00))
                || ((req_size == SIZE_HALF) && req_addr[0])
                || (w_end > MEM_LIMIT);

  lsu_load_extend u_extend (
    .i_rd     (mem_rd),
    .i_size   (r_size),
    .i_signed (r_signed),
    .o_data   (w_ext)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_commit    = 1'b0;
    w_access    = 1'b0;
    req_ready   = 1'b0;
    resp_valid  = 1'b0;
    case (r_state)
      LSU_IDLE: begin
        req_ready = r_alive;
        if (req_valid && r_alive) begin
          w_accept    = 1'b1;
          w_state_nxt = w_fault ? LSU_RESP : LSU_ACCESS;
        end
      end
      LSU_ACCESS: begin
        w_access = 1'b1;
        if (r_wait_cnt == 4'd0) begin
          w_commit    = 1'b1;
          w_state_nxt = LSU_RESP;
        end
      end
      LSU_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) w_state_nxt = LSU_IDLE;
      end
      default: w_state_nxt = LSU_IDLE;
    endcase
  end

  // Memory port is only live during ACCESS; elsewhere it idles with size NONE.
  assign mem_we     = w_commit & r_we;
  assign mem_addr   = w_access ? r_addr  : 32'd0;
  assign mem_wd     = w_access ? r_wdata : 32'd0;
  assign mem_size   = w_access ? r_size  : SIZE_NONE;
  assign resp_rdata = r_rdata;
  assign resp_err   = r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= LSU_IDLE;
      r_alive    <= 1'b0;
      r_we       <= 1'b0;
      r_signed   <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_size     <= SIZE_NONE;
      r_wait_cnt <= '0;
      r_rdata    <= '0;
      r_err      <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_alive <= 1'b1;
      if (w_accept) begin
        r_we       <= req_we;
        r_signed   <= req_signed;
        r_addr     <= req_addr;
        r_wdata    <= req_wdata;
        r_size     <= req_size;
        r_wait_cnt <= WAIT_INIT;
        r_rdata    <= '0;
        r_err      <= w_fault;
      end else if (w_access && (r_wait_cnt != 4'd0)) begin
        r_wait_cnt <= r_wait_cnt - 4'd1;
      end
      if (w_commit && !r_we) r_rdata <= w_ext;
    end
  end

endmodule

// File: tb/tb_lsu_mem_master.sv
// Directed bench for lsu_mem_master: two instances (3 and 2 wait states), each
// attached to a 64-byte big-endian memory model.
module tb_lsu_mem_master;
  import soc_mem_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n_a, rst_n_b;
  logic        req_we, req_signed, resp_ready;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;

  logic        a_req_valid, a_req_ready, a_resp_valid, a_resp_err, a_mem_we;
  logic [31:0] a_resp_rdata, a_mem_addr, a_mem_wd, a_mem_rd;
  logic [1:0]  a_mem_size;
  logic        b_req_valid, b_req_ready, b_resp_valid, b_resp_err, b_mem_we;
  logic [31:0] b_resp_rdata, b_mem_addr, b_mem_wd, b_mem_rd;
  logic [1:0]  b_mem_size;

  logic [7:0]  mem_a [64];
  logic [7:0]  mem_b [64];
  logic        mem_clr;
  int          we_cnt_a = 0;
  int          sz_cnt_a = 0;

  int n_checks = 0;
  int n_fail   = 0;

  lsu_mem_master #(.MEM_BYTES(64), .WAIT_STATES(3)) dut_a (
    .clk(clk), .rst_n(rst_n_a), .req_valid(a_req_valid), .req_ready(a_req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
    .req_signed(req_signed), .resp_valid(a_resp_valid), .resp_ready(resp_ready),
    .resp_rdata(a_resp_rdata), .resp_err(a_resp_err), .mem_we(a_mem_we),
    .mem_addr(a_mem_addr), .mem_wd(a_mem_wd), .mem_size(a_mem_size), .mem_rd(a_mem_rd)
  );

  lsu_mem_master #(.MEM_BYTES(64), .WAIT_STATES(2)) dut_b (
    .clk(clk), .rst_n(rst_n_b), .req_valid(b_req_valid), .req_ready(b_req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
    .req_signed(req_signed), .resp_valid(b_resp_valid), .resp_ready(resp_ready),
    .resp_rdata(b_resp_rdata), .resp_err(b_resp_err), .mem_we(b_mem_we),
    .mem_addr(b_mem_addr), .mem_wd(b_mem_wd), .mem_size(b_mem_size), .mem_rd(b_mem_rd)
  );

  function automatic logic [31:0] pack_rd(input logic [1:0] s, input logic [7:0] b0,
                                          input logic [7:0] b1, input logic [7:0] b2,
                                          input logic [7:0] b3);
    case (s)
      2'b00:   pack_rd = {b0, b1, b2, b3};
      2'b01:   pack_rd = {16'h0, b0, b1};
      2'b10:   pack_rd = {24'h0, b0};
      default: pack_rd = 32'h0;
    endcase
  endfunction

  logic [5:0] aa, ba;
  assign aa = a_mem_addr[5:0];
  assign ba = b_mem_addr[5:0];
  assign a_mem_rd = pack_rd(a_mem_size, mem_a[aa], mem_a[aa+6'd1], mem_a[aa+6'd2], mem_a[aa+6'd3]);
  assign b_mem_rd = pack_rd(b_mem_size, mem_b[ba], mem_b[ba+6'd1], mem_b[ba+6'd2], mem_b[ba+6'd3]);

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 64; i++) mem_a[i] <= 8'h00;
    end else if (a_mem_we) begin
      case (a_mem_size)
        2'b00: begin
          mem_a[aa] <= a_mem_wd[31:24]; mem_a[aa+6'd1] <= a_mem_wd[23:16];
          mem_a[aa+6'd2] <= a_mem_wd[15:8]; mem_a[aa+6'd3] <= a_mem_wd[7:0];
        end
        2'b01: begin mem_a[aa] <= a_mem_wd[15:8]; mem_a[aa+6'd1] <= a_mem_wd[7:0]; end
        2'b10: mem_a[aa] <= a_mem_wd[7:0];
        default: ;
      endcase
    end
    if (a_mem_we) we_cnt_a <= we_cnt_a + 1;
    if (a_mem_size != 2'b11) sz_cnt_a <= sz_cnt_a + 1;
  end

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 64; i++) mem_b[i] <= 8'h00;
    end else if (b_mem_we) begin
      case (b_mem_size)
        2'b00: begin
          mem_b[ba] <= b_mem_wd[31:24]; mem_b[ba+6'd1] <= b_mem_wd[23:16];
          mem_b[ba+6'd2] <= b_mem_wd[15:8]; mem_b[ba+6'd3] <= b_mem_wd[7:0];
        end
        2'b01: begin mem_b[ba] <= b_mem_wd[15:8]; mem_b[ba+6'd1] <= b_mem_wd[7:0]; end
        2'b10: mem_b[ba] <= b_mem_wd[7:0];
        default: ;
      endcase
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // One complete transaction on instance m (0 = dut_a, 1 = dut_b), called at a negedge.
  task automatic xact(input int m, input logic we, input logic [31:0] addr,
                      input logic [31:0] wd, input logic [1:0] sz, input logic sg,
                      output logic [31:0] rd, output logic er, output int lat);
    int guard;
    guard = 0;
    while (!(m == 0 ? a_req_ready : b_req_ready) && guard < 20) begin
      @(negedge clk); guard++;
    end
    req_we = we; req_addr = addr; req_wdata = wd; req_size = sz; req_signed = sg;
    if (m == 0) a_req_valid = 1'b1; else b_req_valid = 1'b1;
    @(negedge clk);
    a_req_valid = 1'b0; b_req_valid = 1'b0;
    lat = 1;
    while (!(m == 0 ? a_resp_valid : b_resp_valid) && lat < 40) begin
      @(negedge clk); lat++;
    end
    check("resp_seen", 32'(m == 0 ? a_resp_valid : b_resp_valid), 32'd1);
    rd = (m == 0) ? a_resp_rdata : b_resp_rdata;
    er = (m == 0) ? a_resp_err : b_resp_err;
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, hold_rd;
    logic        er, stable, rdy_seen;
    int          lat, we0, sz0;

    rst_n_a = 1'b0; rst_n_b = 1'b0; mem_clr = 1'b1;
    a_req_valid = 1'b0; b_req_valid = 1'b0; resp_ready = 1'b0;
    req_we = 1'b0; req_addr = '0; req_wdata = '0; req_size = SIZE_WORD; req_signed = 1'b0;
    repeat (2) @(negedge clk);

    check("rst_req_ready", 32'(a_req_ready), 32'd0);
    check("rst_resp_valid", 32'(a_resp_valid), 32'd0);
    check("rst_resp_rdata", a_resp_rdata, 32'd0);
    check("rst_resp_err", 32'(a_resp_err), 32'd0);
    check("rst_mem_we", 32'(a_mem_we), 32'd0);
    check("rst_mem_addr", a_mem_addr, 32'd0);
    check("rst_mem_wd", a_mem_wd, 32'd0);
    check("rst_mem_size", 32'(a_mem_size), 32'd3);

    mem_clr = 1'b0; rst_n_a = 1'b1; rst_n_b = 1'b1;
    @(negedge clk);
    check("post_rst_req_ready", 32'(a_req_ready), 32'd1);

    xact(0, 1'b1, 32'h10, 32'hDEADBEEF, SIZE_WORD, 1'b0, rd, er, lat);
    check("st_w_err", 32'(er), 32'd0);
    check("st_w_rdata", rd, 32'd0);
    check("st_w_latency", 32'(lat), 32'd5);
    check("mem_bytes_10", {mem_a[16], mem_a[17], mem_a[18], mem_a[19]}, 32'hDEADBEEF);

    xact(0, 1'b0, 32'h10, 32'h0, SIZE_WORD, 1'b0, rd, er, lat);
    check("ld_w_rdata", rd, 32'hDEADBEEF);
    check("ld_w_err", 32'(er), 32'd0);
    xact(0, 1'b0, 32'h11, 32'h0, SIZE_BYTE, 1'b1, rd, er, lat);
    check("ld_b_signed", rd, 32'hFFFFFFAD);
    xact(0, 1'b0, 32'h11, 32'h0, SIZE_BYTE, 1'b0, rd, er, lat);
    check("ld_b_unsigned", rd, 32'h000000AD);
    xact(0, 1'b0, 32'h12, 32'h0, SIZE_HALF, 1'b1, rd, er, lat);
    check("ld_h_signed", rd, 32'hFFFFBEEF);
    xact(0, 1'b0, 32'h10, 32'h0, SIZE_HALF, 1'b0, rd, er, lat);
    check("ld_h_unsigned", rd, 32'h0000DEAD);

    we0 = we_cnt_a; sz0 = sz_cnt_a;
    xact(0, 1'b0, 32'h02, 32'h0, SIZE_WORD, 1'b0, rd, er, lat);
    check("mis_w_err", 32'(er), 32'd1);
    check("mis_w_rdata", rd, 32'd0);
    check("fault_latency", 32'(lat), 32'd1);
    xact(0, 1'b0, 32'h03, 32'h0, SIZE_HALF, 1'b0, rd, er, lat);
    check("mis_h_err", 32'(er), 32'd1);
    check("mis_h_rdata", rd, 32'd0);
    xact(0, 1'b1, 32'h3D, 32'h11223344, SIZE_WORD, 1'b0, rd, er, lat);
    check("st_fault_err", 32'(er), 32'd1);
    check("fault_no_we", 32'(we_cnt_a - we0), 32'd0);
    check("fault_no_size", 32'(sz_cnt_a - sz0), 32'd0);

    xact(0, 1'b0, 32'h3C, 32'h0, SIZE_WORD, 1'b0, rd, er, lat);
    check("ld_3c_err", 32'(er), 32'd0);
    check("ld_3c_rdata", rd, 32'd0);
    xact(0, 1'b0, 32'h40, 32'h0, SIZE_WORD, 1'b0, rd, er, lat);
    check("ld_40_err", 32'(er), 32'd1);
    xact(0, 1'b0, 32'h10, 32'h0, SIZE_NONE, 1'b0, rd, er, lat);
    check("size11_err", 32'(er), 32'd1);
    xact(0, 1'b0, 32'hFFFFFFFC, 32'h0, SIZE_WORD, 1'b0, rd, er, lat);
    check("wrap_err", 32'(er), 32'd1);

    xact(0, 1'b1, 32'h3F, 32'hFFFFFF5A, SIZE_BYTE, 1'b0, rd, er, lat);
    check("st_b_3f_err", 32'(er), 32'd0);
    xact(0, 1'b0, 32'h3E, 32'h0, SIZE_HALF, 1'b0, rd, er, lat);
    check("ld_h_3e", rd, 32'h0000005A);
    check("ld_h_3e_err", 32'(er), 32'd0);
    xact(0, 1'b1, 32'h14, 32'h00001234, SIZE_HALF, 1'b0, rd, er, lat);
    xact(0, 1'b0, 32'h14, 32'h0, SIZE_WORD, 1'b0, rd, er, lat);
    check("st_h_mapping", rd, 32'h12340000);

    // Held response: resp_ready low for 5 cycles after resp_valid rises.
    req_we = 1'b0; req_addr = 32'h10; req_size = SIZE_WORD; req_signed = 1'b0;
    a_req_valid = 1'b1; rdy_seen = 1'b0;
    @(negedge clk);
    a_req_valid = 1'b0; lat = 1;
    while (!a_resp_valid && lat < 40) begin
      if (a_req_ready) rdy_seen = 1'b1;
      @(negedge clk); lat++;
    end
    check("hold_latency", 32'(lat), 32'd5);
    hold_rd = a_resp_rdata; stable = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (!a_resp_valid || a_resp_rdata !== hold_rd || a_resp_err || a_req_ready) stable = 1'b0;
    end
    check("hold_stable", 32'(stable), 32'd1);
    check("hold_rdata", hold_rd, 32'hDEADBEEF);
    check("hold_no_ready_in_flight", 32'(rdy_seen), 32'd0);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    check("hold_released_valid", 32'(a_resp_valid), 32'd0);
    check("hold_released_ready", 32'(a_req_ready), 32'd1);

    // Reset asserted in the commit cycle of a store on the 2-wait-state instance.
    req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'hCAFEF00D; req_size = SIZE_WORD;
    b_req_valid = 1'b1;
    @(negedge clk);
    b_req_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("b_commit_we", 32'(b_mem_we), 32'd1);
    rst_n_b = 1'b0;
    #1;
    check("b_rst_mem_we", 32'(b_mem_we), 32'd0);
    check("b_rst_mem_size", 32'(b_mem_size), 32'd3);
    check("b_rst_mem_addr", b_mem_addr, 32'd0);
    check("b_rst_req_ready", 32'(b_req_ready), 32'd0);
    check("b_rst_resp_valid", 32'(b_resp_valid), 32'd0);
    @(negedge clk);
    rst_n_b = 1'b1;
    check("b_abort_bytes", {mem_b[32], mem_b[33], mem_b[34], mem_b[35]}, 32'd0);
    @(negedge clk);
    check("b_post_rst_ready", 32'(b_req_ready), 32'd1);
    xact(1, 1'b1, 32'h20, 32'h01020304, SIZE_WORD, 1'b0, rd, er, lat);
    check("b_store_err", 32'(er), 32'd0);
    check("b_store_latency", 32'(lat), 32'd4);
    xact(1, 1'b0, 32'h20, 32'h0, SIZE_WORD, 1'b0, rd, er, lat);
    check("b_load_rdata", rd, 32'h01020304);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
